// File: rtl/quadrature_step_decoder.sv
// quadrature_step_decoder: synchronizes two quadrature channels, optionally
// glitch-filters them, decodes legal Gray transitions into one-cycle steps with
// a direction, and keeps a presettable wrapping position count plus a sticky
// error flag for double-bit jumps.
// Optional feature macro: QDEC_GLITCH_FILTER_EN (per-channel stability filter).
module quadrature_step_decoder #(
  parameter int WIDTH      = 16,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             preset,
  input  logic [WIDTH-1:0] preset_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             err
);

  // Channel pairs are packed as {A, B} throughout.
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] f;

  // Two-stage synchronizer inputs: stage 1 samples the pins, stage 2 follows stage 1.
  always_comb begin
    s1_d = {enc_a, enc_b};
    s2_d = s1_q;
  end

  // Synchronizer registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int SETTLE = 3 + FILTER_LEN;
  localparam int CNT_W  = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       f_q, f_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  // A channel level is accepted only after it has differed from the filtered
  // level for FILTER_LEN consecutive edges; any return to agreement restarts it.
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != f_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          f_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Filter registers: filtered levels and per-channel stability counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q      <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      f_q      <= f_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign f = f_q;
`else
  localparam int SETTLE = 3;

  assign f = s2_q;
`endif

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [1:0]       prev_q, prev_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             is_up, is_down, is_illegal;

  // Classify the move from the previous filtered pair to the current one.
  // Up order is 00 -> 10 -> 11 -> 01 -> 00; the reverse is down; a change of
  // both bits at once cannot be attributed to a direction.
  always_comb begin
    is_up      = 1'b0;
    is_down    = 1'b0;
    is_illegal = 1'b0;
    case ({prev_q, f})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_up      = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: is_down    = 1'b1;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: is_illegal = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic: INIT waits for the synchronizer and filter to settle
  // before latching a reference pair; TRACK turns moves into steps. A new error
  // overrides err_clr, and preset overrides any count change.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    prev_d   = prev_q;
    pos_d    = pos_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    err_d    = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    case (state_q)
      INIT: begin
        if (settle_q == SETTLE_LAST) begin
          prev_d   = f;
          state_d  = TRACK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      TRACK: begin
        prev_d = f;
        if (is_up) begin
          step_d = 1'b1;
          dir_d  = 1'b1;
          pos_d  = pos_q + 1'b1;
        end else if (is_down) begin
          step_d = 1'b1;
          dir_d  = 1'b0;
          pos_d  = pos_q - 1'b1;
        end else if (is_illegal) begin
          err_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
    if (preset) begin
      pos_d = preset_val;
    end
  end

  // Decoder state and registered outputs; reset discards any pending step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= INIT;
      settle_q <= '0;
      prev_q   <= 2'b00;
      pos_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      prev_q   <= prev_d;
      pos_q    <= pos_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  assign pos  = pos_q;
  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;

endmodule

// File: doc/quadrature_step_decoder.md
# quadrature_step_decoder

Receive-side front end for the team's up/down position counters. It takes two asynchronous quadrature channels, A and B, and synchronizes them. An optional glitch filter follows, then a Gray-sequence state machine decodes each legal transition into a one-cycle step with a direction. The block also keeps its own presettable WIDTH-bit position count and a sticky error flag for illegal double-bit transitions.

## Interface
- `WIDTH`, default 16: position counter width; must be ≥ 2.
- `FILTER_LEN`, default 4: number of consecutive stable cycles needed to accept a new channel level; must be ≥ 1. Used only when the filter is compiled in.
- `clk` in, 1: single clock; all logic is on its rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `enc_a` in, 1: quadrature channel A, asynchronous to `clk`.
- `enc_b` in, 1: quadrature channel B, asynchronous to `clk`.
- `preset` in, 1: when high, loads `preset_val` into `pos` at the next edge.
- `preset_val` in, WIDTH: value loaded by `preset`.
- `err_clr` in, 1: clears the sticky `err` flag.
- `pos` out, WIDTH: current position count.
- `step` out, 1: one-cycle pulse for each legal transition.
- `dir` out, 1: direction of the most recent step; 1 = up, 0 = down.
- `err` out, 1: sticky flag, set by an illegal transition (both channels changed in one cycle).

## Operation
- **Synchronizer:** each channel passes through 2 flip-flops (`s1`, `s2`). Reset clears both stages to 0.
- **Filter:** produces the filtered pair `f = {fa, fb}`. Behaviour depends on the configuration macro; see Configuration.
- **FSM, state INIT:** entered on reset. A settle counter runs for SETTLE edges after reset deasserts.
  - SETTLE = 3 without the filter; 3 + FILTER_LEN with the filter.
  - No `step` and no `err` are produced in INIT.
  - On the last INIT edge, the FSM copies `f` into `prev` and moves to TRACK.
- **FSM, state TRACK:** each edge compares `f` against `prev`, then sets `prev <= f`.
  - Up sequence: 00→10→11→01→00 (A leads B). Result: `step=1`, `dir=1`, `pos <= pos+1`.
  - Down sequence: the reverse. Result: `step=1`, `dir=0`, `pos <= pos-1`.
  - `f == prev`: `step=0`; `dir` and `pos` hold.
  - Both bits differ (illegal): `err <= 1`, `step=0`, `pos` and `dir` hold.
- **Arithmetic:** `pos` wraps modulo 2^WIDTH. All-ones + 1 = 0; 0 − 1 = all-ones. There is no saturation and no carry output.
- **Priority rules:**
  - `preset` beats a step in the same cycle: `pos <= preset_val` and the step's count change is dropped. `step` and `dir` still report the transition.
  - A new error beats `err_clr` in the same cycle: `err` stays 1.
  - `preset` in INIT is honoured.
- **Reset mid-operation:** all state returns to reset values at the next edge and the FSM re-enters INIT. The pending step is discarded.

## Timing
- **Reset values:** `pos=0`, `step=0`, `dir=0`, `err=0`, FSM=INIT, `prev=00`, filter counters 0, filtered levels 0.
- **Latency without the filter:** a channel change captured into `s1` at edge N gives `step`, `dir` and `pos` updated at edge N+2.
- **Latency with the filter:** `s2` changes at edge N+1; `f` updates at edge N+1+FILTER_LEN; `step`, `dir` and `pos` update at edge N+2+FILTER_LEN.
- **Register timing:** `step` is high for exactly one cycle per decoded transition. Every output is registered.
- **Preset:** `pos` reflects `preset_val` one edge after `preset` is sampled high.
- **Maximum input rate:** one legal transition per (FILTER_LEN+1) cycles with the filter; one per cycle without it. Faster inputs may be reported as illegal.

## Configuration
- **Macro:** `QDEC_GLITCH_FILTER_EN`.
- **With the macro defined:**
  - Each channel has a counter of width ⌈log2(FILTER_LEN+1)⌉.
  - While `s2 != f` the counter increments; when `s2 == f` it clears.
  - When `s2` has differed from `f` on FILTER_LEN consecutive edges, `f <= s2` and the counter clears.
  - Pulses shorter than FILTER_LEN cycles are rejected.
- **Without the macro:** `f = s2` directly, no filter logic is generated, and SETTLE = 3.

## Test plan
- **Reset and INIT:** hold A=B=1 through reset, then release → no `step` and no `err` during INIT; `pos=0` after INIT.
- **Forward sweep:** drive 00→10→11→01→00, each level held FILTER_LEN+2 cycles → 4 `step` pulses, `dir=1`, `pos` = 0x0004.
- **Wrap with reverse:** `preset` with `preset_val`=0x0000, then drive one down transition → `pos` = 0xFFFF, `dir=0`; then drive one up transition → `pos` = 0x0000.
- **Illegal transition and clear:** jump 00→11 in one cycle → `err=1`, no `step`, `pos` unchanged; then `err_clr` coincident with a second 11→00 jump → `err` stays 1; `err_clr` alone → `err=0`.
- **Preset collides with step:** `preset=1`, `preset_val`=0x1234 on the same edge as an up step → `pos` = 0x1234, `step=1`, `dir=1`.
- **Glitch rejection (filter compiled in):** a 2-cycle pulse on A with FILTER_LEN=4 → no `step`, `pos` unchanged. The same pulse with the filter compiled out → 2 `step` pulses (up, then down), and the net `pos` is unchanged.
